// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller FIFO set among NUM_PORTS requesters.
// Define SDRAM_ARB_PORT0_PRIO_EN to give port 0 absolute priority over the round-robin ports.
module sdram_port_arbiter #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned TAG_ADDR_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_valid_i,
    output logic [NUM_PORTS-1:0]    req_ready_o,
    input  logic [NUM_PORTS-1:0]    req_we_i,
    input  logic [NUM_PORTS-1:0]    req_burst_i,
    input  logic [NUM_PORTS*24-1:0] req_addr_i,
    input  logic [NUM_PORTS*16-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]    rsp_valid_o,
    output logic [15:0]             rsp_data_o,
    output logic [NUM_PORTS-1:0]    rsp_burst_valid_o,
    output logic [127:0]            rsp_burst_data_o,
    output logic [40:0]             cmd_d_o,
    output logic                    cmd_enq_o,
    input  logic                    cmd_alm_full_i,
    output logic [31:0]             burst_d_o,
    output logic                    burst_enq_o,
    input  logic                    burst_alm_full_i,
    input  logic [15:0]             rd_q_i,
    output logic                    rd_deq_o,
    input  logic                    rd_empty_i,
    input  logic [127:0]            rd_burst_q_i,
    output logic                    rd_burst_deq_o,
    input  logic                    rd_burst_empty_i,
    output logic                    err_o
);
    localparam int unsigned PW    = $clog2(NUM_PORTS);
    localparam int unsigned IW    = PW + 1;
    localparam int unsigned DEPTH = 1 << TAG_ADDR_LEN;
    localparam int unsigned CW    = TAG_ADDR_LEN + 1;

    typedef enum logic [1:0] {StIdle, StDeq, StCapture} rsp_state_e;

    // Class index 0 = single read, 1 = burst read.
    logic [PW-1:0]           tag_mem   [2][DEPTH];
    logic [TAG_ADDR_LEN-1:0] tag_wp_q  [2];
    logic [TAG_ADDR_LEN-1:0] tag_rp_q  [2];
    logic [CW-1:0]           tag_cnt_q [2];
    logic [1:0]              tag_full, push, pop, orphan, deq, capture, data_empty;
    rsp_state_e              st_q [2];
    rsp_state_e              st_d [2];

    logic [NUM_PORTS-1:0] eligible;
    logic [PW-1:0]        rr_q, rr_d, win;
    logic [IW-1:0]        idx;
    logic                 grant, win_we, win_burst;
    logic [23:0]          win_addr;
    logic [15:0]          win_data;

    logic [40:0]          cmd_d_q;
    logic [31:0]          burst_d_q;
    logic                 cmd_enq_q, burst_enq_q, err_q;
    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_burst_valid_q;
    logic [15:0]          rsp_data_q;
    logic [127:0]         rsp_burst_q;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            tag_full[c] = (tag_cnt_q[c] == CW'(DEPTH));
        end
    end

    // No grant while in reset so that no request is acknowledged and then lost.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_we_i[p]) begin
                eligible[p] = req_valid_i[p] && !rst_i && !cmd_alm_full_i;
            end else if (req_burst_i[p]) begin
                eligible[p] = req_valid_i[p] && !rst_i && !burst_alm_full_i && !tag_full[1];
            end else begin
                eligible[p] = req_valid_i[p] && !rst_i && !cmd_alm_full_i && !tag_full[0];
            end
        end
    end

    always_comb begin
        grant = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_q} + IW'(i);
            if (idx >= IW'(NUM_PORTS)) idx = idx - IW'(NUM_PORTS);
            if (!grant && eligible[idx[PW-1:0]]) begin
                grant = 1'b1;
                win   = idx[PW-1:0];
            end
        end
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        if (eligible[0]) begin
            grant = 1'b1;
            win   = '0;
        end
`endif
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        if (grant && win == '0) rr_d = rr_q;
`endif
    end

    always_comb begin
        req_ready_o = '0;
        if (grant) req_ready_o[win] = 1'b1;
    end

    assign win_we    = req_we_i[win];
    assign win_burst = !win_we && req_burst_i[win];
    assign win_addr  = req_addr_i[win*24 +: 24];
    assign win_data  = req_data_i[win*16 +: 16];
    assign push[0]   = grant && !win_we && !win_burst;
    assign push[1]   = grant && win_burst;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rr_q        <= '0;
            cmd_d_q     <= '0;
            burst_d_q   <= '0;
            cmd_enq_q   <= 1'b0;
            burst_enq_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            cmd_enq_q   <= grant && !win_burst;
            burst_enq_q <= grant && win_burst;
            if (grant && !win_burst) cmd_d_q <= {win_we, win_addr, win_data};
            if (grant && win_burst) burst_d_q <= {8'h00, win_addr};
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) tag_mem[c][tag_wp_q[c]] <= win;
            if (rst_i) begin
                tag_wp_q[c]  <= '0;
                tag_rp_q[c]  <= '0;
                tag_cnt_q[c] <= '0;
            end else begin
                if (push[c]) tag_wp_q[c] <= tag_wp_q[c] + 1'b1;
                if (pop[c]) tag_rp_q[c] <= tag_rp_q[c] + 1'b1;
                if (push[c] && !pop[c]) tag_cnt_q[c] <= tag_cnt_q[c] + 1'b1;
                else if (!push[c] && pop[c]) tag_cnt_q[c] <= tag_cnt_q[c] - 1'b1;
            end
        end
    end

    assign data_empty = {rd_burst_empty_i, rd_empty_i};

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            st_q[c] <= rst_i ? StIdle : st_d[c];
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c] = st_q[c];
            unique case (st_q[c])
                StIdle:    if (!data_empty[c]) st_d[c] = StDeq;
                StDeq:     st_d[c] = StCapture;
                StCapture: st_d[c] = StIdle;
                default:   st_d[c] = StIdle;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            deq[c]     = (st_q[c] == StDeq);
            capture[c] = (st_q[c] == StCapture);
            pop[c]     = capture[c] && (tag_cnt_q[c] != '0);
            orphan[c]  = capture[c] && (tag_cnt_q[c] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rsp_valid_q       <= '0;
            rsp_burst_valid_q <= '0;
            rsp_data_q        <= '0;
            rsp_burst_q       <= '0;
            err_q             <= 1'b0;
        end else begin
            rsp_valid_q       <= '0;
            rsp_burst_valid_q <= '0;
            if (pop[0]) begin
                rsp_valid_q[tag_mem[0][tag_rp_q[0]]] <= 1'b1;
                rsp_data_q                           <= rd_q_i;
            end
            if (pop[1]) begin
                rsp_burst_valid_q[tag_mem[1][tag_rp_q[1]]] <= 1'b1;
                rsp_burst_q                                <= rd_burst_q_i;
            end
            if (|orphan) err_q <= 1'b1;
        end
    end

    assign cmd_d_o           = cmd_d_q;
    assign cmd_enq_o         = cmd_enq_q;
    assign burst_d_o         = burst_d_q;
    assign burst_enq_o       = burst_enq_q;
    assign rd_deq_o          = deq[0];
    assign rd_burst_deq_o    = deq[1];
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_data_o        = rsp_data_q;
    assign rsp_burst_valid_o = rsp_burst_valid_q;
    assign rsp_burst_data_o  = rsp_burst_q;
    assign err_o             = err_q;

endmodule
